prio_encoder_rr: RTL and testbench
==================================

// Module: prio_encoder_rr
// PURPOSE
//  Parametrised N-to-log2(N) priority encoder with a registered output stage
//  and a valid/ready handshake. Supports fixed-priority and round-robin modes.
//  Sits between a request vector (IRQ lines, arbiter requests) and a consumer
//  that may apply backpressure. It replaces the fixed 16-to-4 combinational encoder.
// PARAMETERS
//  N      16   number of request inputs; N >= 2
//  IDX_W  $clog2(N)  derived localparam; width of out_idx; not overridable
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  en          in   1      capture enable; 0 = output stage holds its contents
//  mode        in   1      0 = fixed priority (highest index wins), 1 = round-robin
//  req         in   N      request vector; bit k = requester k
//  out_ready   in   1      consumer accepts the current output
//  out_valid   out  1      out_idx/out_onehot/out_multi hold a valid grant
//  out_idx     out  IDX_W  binary index of the granted request
//  out_onehot  out  N      one-hot grant; bit out_idx is set when valid, else all 0
//  out_multi   out  1      more than one req bit was set at capture
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, out_idx=0, out_onehot=0, out_multi=0,
//   rr pointer ptr=0. Release is synchronous to clk.
//  Slot free: free = !out_valid || out_ready.
//  Capture: on a clk edge with en=1 and free=1:
//   - req != 0: load the grant, out_valid=1. Latency is 1 cycle from req to outputs.
//   - req == 0: out_valid=0, and out_idx/out_onehot/out_multi clear to 0.
//  Hold: if en=0, or out_valid=1 with out_ready=0, all outputs and ptr are
//   unchanged. Changes to req are ignored; there is no glitch and no overwrite.
//  Fixed mode (mode=0): grant = highest set bit of req. ptr is not modified.
//  Round-robin mode (mode=1): scan from index ptr upward and wrap N-1 -> 0.
//   The grant is the first set bit found. On capture, ptr = (grant+1) mod N.
//   Wrap: with ptr=N-1, bit N-1 is checked first, then bit 0.
//  Mode is sampled at the capture edge. Switching mode does not reset ptr.
//  out_multi = (popcount(req) > 1) at capture. It does not depend on mode.
//  Simultaneous out_ready=1 and a new capture in the same cycle: the old
//   grant is consumed and the new one loads. Throughput is 1 grant per cycle.
//  X on req while en=0 or while stalled must not propagate to the outputs.
//  Reset mid-operation: any pending grant is discarded and ptr returns to 0.
// TESTING  (N=16, en=1 unless stated)
//  1 Reset: rst_n=0 with req=16'hFFFF -> out_valid=0, out_idx=0,
//    out_onehot=0, out_multi=0. The first rr grant after release
//    with req=16'h0001 is idx 0.
//  2 Fixed: mode=0, out_ready=1, req=16'h3200 -> next cycle out_valid=1,
//    out_idx=13, out_onehot=16'h2000, out_multi=1. req=16'h0140 -> idx 8.
//  3 Round-robin: mode=1, out_ready=1, req=16'h0011 held -> grants 0,4,0,4.
//    Then req=16'h8001 with ptr=15 -> idx 15, then idx 0 (wrap).
//  4 Backpressure: grant idx 5 valid, out_ready=0, req changes to 16'h0800
//    for 3 cycles -> outputs stay at idx 5. On out_ready=1 -> next cycle
//    shows idx 11.
//  5 Empty/enable: req=0 with slot free -> out_valid=0 next cycle.
//    en=0 with a valid grant -> outputs and ptr are frozen, even with out_ready=1.
//  6 Reset mid-op: in rr mode with ptr=9, pulse rst_n low between edges ->
//    outputs clear immediately. Then req=16'hFFFF -> idx 0.

Source files
------------

// File: rtl/prio_encoder_rr.sv
// N-to-log2(N) priority encoder, fixed or round-robin. Grant is registered with one cycle of latency.
// The output slot holds while valid and not ready, or while en is low. req is ignored whenever it holds.
module prio_encoder_rr #(
    parameter  int N     = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [N-1:0]     req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot,
    output logic             out_multi
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] fix_idx;
    logic [IDX_W-1:0] rr_hi_idx;
    logic [IDX_W-1:0] rr_lo_idx;
    logic             rr_hi_found;
    logic [IDX_W-1:0] grant_idx;
    logic [N-1:0]     grant_onehot;
    logic             req_any;
    logic             req_multi;
    logic             slot_free;
    logic             capture;

    assign slot_free = !out_valid || out_ready;
    assign capture   = en && slot_free;
    assign req_any   = |req;
    assign req_multi = |(req & (req - N'(1)));

    // Fixed priority: the last set bit seen while scanning upward is the highest.
    always_comb begin
        fix_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (req[k]) begin
                fix_idx = IDX_W'(k);
            end
        end
    end

    // Round-robin: lowest set bit at or above ptr, otherwise wrap to the lowest set bit overall.
    always_comb begin
        rr_hi_found = 1'b0;
        rr_hi_idx   = '0;
        rr_lo_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                rr_lo_idx = IDX_W'(k);
            end
            if (req[k] && (k >= int'(ptr))) begin
                rr_hi_found = 1'b1;
                rr_hi_idx   = IDX_W'(k);
            end
        end
    end

    always_comb begin
        grant_idx    = mode ? (rr_hi_found ? rr_hi_idx : rr_lo_idx) : fix_idx;
        grant_onehot = N'(1) << grant_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            out_multi  <= 1'b0;
        end else if (capture) begin
            if (req_any) begin
                out_valid  <= 1'b1;
                out_idx    <= grant_idx;
                out_onehot <= grant_onehot;
                out_multi  <= req_multi;
            end else begin
                out_valid  <= 1'b0;
                out_idx    <= '0;
                out_onehot <= '0;
                out_multi  <= 1'b0;
            end
        end
    end

    // ptr only advances on a real round-robin grant, so fixed mode leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (capture && req_any && mode) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: directed vector table, mid-operation reset, then random traffic against a reference model.
module tb_prio_encoder_rr;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          mode;
    logic [N-1:0]  req;
    logic          out_ready;
    logic          out_valid;
    logic [3:0]    out_idx;
    logic [N-1:0]  out_onehot;
    logic          out_multi;

    int errors = 0;
    int checks = 0;

    prio_encoder_rr #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .req        (req),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_multi  (out_multi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        mode;
        logic        rdy;
        logic [15:0] req;
        logic        ev;
        logic [3:0]  ei;
        logic        em;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [3:0] ei, input logic em);
        logic [N-1:0] eoh;
        eoh = ev ? (N'(1) << ei) : '0;
        chk({tag, "_valid"},  32'(out_valid),  32'(ev));
        chk({tag, "_idx"},    32'(out_idx),    ev ? 32'(ei) : 32'd0);
        chk({tag, "_onehot"}, 32'(out_onehot), 32'(eoh));
        chk({tag, "_multi"},  32'(out_multi),  ev ? 32'(em) : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic       m_valid;
    logic [3:0] m_idx;
    logic       m_multi;
    int         m_ptr;

    function automatic int ref_grant(input logic [N-1:0] r, input logic md, input int p);
        int g;
        g = 0;
        if (!md) begin
            for (int k = 0; k < N; k++) if (r[k]) g = k;
        end else begin
            for (int s = N - 1; s >= 0; s--) if (r[(p + s) % N]) g = (p + s) % N;
        end
        return g;
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 1'b0; req = 16'hFFFF; out_ready = 1'b1;

        // Reset with all requests asserted
        #12;
        chk_out("reset", 1'b0, 4'd0, 1'b0);
        step();
        chk_out("reset_hold", 1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;

        //            en    mode  rdy   req        ev    ei     em
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 4'd0,  1'b0}); // first rr grant
        tbl.push_back('{1'b1, 1'b0, 1'b1, 16'h3200, 1'b1, 4'd13, 1'b1}); // fixed
        tbl.push_back('{1'b1, 1'b0, 1'b1, 16'h0140, 1'b1, 4'd8,  1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'h8000, 1'b1, 4'd15, 1'b0}); // ptr 1 -> 0
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'h0011, 1'b1, 4'd0,  1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'h0011, 1'b1, 4'd4,  1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'h0011, 1'b1, 4'd0,  1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'h0011, 1'b1, 4'd4,  1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'h4000, 1'b1, 4'd14, 1'b0}); // ptr -> 15
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'h8001, 1'b1, 4'd15, 1'b1}); // wrap
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'h8001, 1'b1, 4'd0,  1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'h0020, 1'b1, 4'd5,  1'b0}); // ptr -> 6
        tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0800, 1'b1, 4'd5,  1'b0}); // stalled
        tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0800, 1'b1, 4'd5,  1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0800, 1'b1, 4'd5,  1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'h0800, 1'b1, 4'd11, 1'b0}); // ptr -> 12
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 4'd0,  1'b0}); // empty
        tbl.push_back('{1'b1, 1'b0, 1'b1, 16'h0003, 1'b1, 4'd1,  1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 4'd1,  1'b1}); // en=0 freezes
        tbl.push_back('{1'b0, 1'b1, 1'b1, 16'hxxxx, 1'b1, 4'd1,  1'b1}); // X while disabled
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 4'd12, 1'b1}); // ptr still 12
        tbl.push_back('{1'b1, 1'b1, 1'b0, 16'hxxxx, 1'b1, 4'd12, 1'b1}); // X while stalled
        tbl.push_back('{1'b1, 1'b0, 1'b1, 16'h0100, 1'b1, 4'd8,  1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'h0100, 1'b1, 4'd8,  1'b0}); // ptr -> 9

        for (int i = 0; i < tbl.size(); i++) begin
            en = tbl[i].en; mode = tbl[i].mode; out_ready = tbl[i].rdy; req = tbl[i].req;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].em);
        end

        // Reset pulse between edges with ptr=9 and a grant pending
        rst_n = 1'b0;
        #1;
        chk_out("midrst", 1'b0, 4'd0, 1'b0);
        #1;
        rst_n = 1'b1;
        en = 1'b1; mode = 1'b1; out_ready = 1'b1; req = 16'hFFFF;
        step();
        chk_out("after_midrst", 1'b1, 4'd0, 1'b1);

        // Random traffic from the known state: grant 0 valid, ptr 1
        m_valid = 1'b1; m_idx = 4'd0; m_multi = 1'b1; m_ptr = 1;
        for (int c = 0; c < 3000; c++) begin
            int sel;
            int g;
            en        = ($urandom_range(7) != 0);
            mode      = $urandom_range(1);
            out_ready = ($urandom_range(3) != 0);
            sel = $urandom_range(3);
            case (sel)
                0: req = '0;
                1: req = N'(1) << $urandom_range(N - 1);
                2: req = N'($urandom) & N'($urandom);
                default: req = N'($urandom);
            endcase
            if (en && (!m_valid || out_ready)) begin
                if (req == '0) begin
                    m_valid = 1'b0; m_idx = 4'd0; m_multi = 1'b0;
                end else begin
                    g = ref_grant(req, mode, m_ptr);
                    m_valid = 1'b1;
                    m_idx   = 4'(g);
                    m_multi = ($countones(req) > 1);
                    if (mode) m_ptr = (g + 1) % N;
                end
            end
            step();
            chk_out($sformatf("rnd%0d", c), m_valid, m_idx, m_multi);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
